// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: controller state encoding, a
// counter-width helper, and the default frame geometry. The transmitter
// and baud generator use the same defaults.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   // Bits needed to hold values 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit. The reset
// value is a parameter so an idle-high line can be preset to 1.
module sync_2ff #(
   parameter bit RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two back-to-back flops resolve metastability before use.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit detection and validation, mid-bit
// sampling, shift strobes into an external SIPO, stop-bit check and a
// valid/ack handshake with overrun detection.
// Optional parity stage is built when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic baud_tick,
   input  logic rx_in,
   input  logic data_ack,
   output logic shift,
   output logic sipo_in,
   output logic data_valid,
   output logic frame_err,
   output logic overrun_err,
   output logic busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic parity_err
`endif
);

   localparam int CNT_W = clog2(OVERSAMPLE);
   localparam int BIT_W = clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   rx_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_sample_cnt, w_sample_cnt_nxt;
   logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic             w_rx_s;
   logic             r_rx_d;
   logic             r_data_valid;
   logic             w_shift;
   logic             w_good_stop;
   logic             w_frame_err;
`ifdef UART_RX_PARITY_EN
   logic             r_par, w_par_nxt;
   logic             r_par_bad, w_par_bad_nxt;
   logic             w_parity_err;
`endif

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (rx_in),
      .o_q (w_rx_s)
   );

   // Delay flop for falling-edge detection; preset high so reset never looks like a start.
   always_ff @(posedge clk) begin
      if (rst) r_rx_d <= 1'b1;
      else     r_rx_d <= w_rx_s;
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
`ifdef UART_RX_PARITY_EN
         r_par        <= 1'b0;
         r_par_bad    <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_sample_cnt <= w_sample_cnt_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
`ifdef UART_RX_PARITY_EN
         r_par        <= w_par_nxt;
         r_par_bad    <= w_par_bad_nxt;
`endif
      end
   end

   // Next-state logic; strobes fire on the baud tick that lands mid-bit.
   always_comb begin
      w_state_nxt      = r_state;
      w_sample_cnt_nxt = r_sample_cnt;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_shift          = 1'b0;
      w_good_stop      = 1'b0;
      w_frame_err      = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_nxt        = r_par;
      w_par_bad_nxt    = r_par_bad;
      w_parity_err     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (r_rx_d && !w_rx_s) begin
               w_state_nxt      = ST_START;
               w_sample_cnt_nxt = '0;
            end
         end
         ST_START: begin
            if (baud_tick) begin
               if (r_sample_cnt == MID_START) begin
                  w_sample_cnt_nxt = '0;
                  if (!w_rx_s) begin
                     w_state_nxt   = ST_DATA;
                     w_bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                     w_par_nxt     = 1'b0;
                     w_par_bad_nxt = 1'b0;
`endif
                  end else begin
                     // Line back high at mid start bit: a glitch, drop silently.
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_sample_cnt_nxt = r_sample_cnt + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (r_sample_cnt == MID_BIT) begin
                  w_sample_cnt_nxt = '0;
                  w_shift          = 1'b1;
                  w_bit_cnt_nxt    = r_bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                  w_par_nxt        = r_par ^ w_rx_s;
                  if (r_bit_cnt == LAST_BIT) w_state_nxt = ST_PARITY;
`else
                  if (r_bit_cnt == LAST_BIT) w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_sample_cnt_nxt = r_sample_cnt + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (baud_tick) begin
               if (r_sample_cnt == MID_BIT) begin
                  // Parity bit is checked here but never shifted into the SIPO.
                  w_sample_cnt_nxt = '0;
                  w_par_bad_nxt    = w_rx_s ^ r_par ^ PARITY_ODD;
                  w_state_nxt      = ST_STOP;
               end else begin
                  w_sample_cnt_nxt = r_sample_cnt + 1'b1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (baud_tick) begin
               if (r_sample_cnt == MID_BIT) begin
                  w_sample_cnt_nxt = '0;
                  w_state_nxt      = ST_IDLE;
                  if (!w_rx_s) begin
                     w_frame_err = 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  else if (r_par_bad) begin
                     w_parity_err = 1'b1;
                  end
`endif
                  else begin
                     w_good_stop = 1'b1;
                  end
               end else begin
                  w_sample_cnt_nxt = r_sample_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Byte-ready flag: a good stop wins over a same-cycle ack.
   always_ff @(posedge clk) begin
      if (rst)              r_data_valid <= 1'b0;
      else if (w_good_stop) r_data_valid <= 1'b1;
      else if (data_ack)    r_data_valid <= 1'b0;
   end

   // Pulses are suppressed while reset is asserted so a mid-frame reset drops them.
   assign shift       = w_shift & ~rst;
   assign sipo_in     = w_shift & w_rx_s & ~rst;
   assign frame_err   = w_frame_err & ~rst;
   assign overrun_err = w_good_stop & r_data_valid & ~data_ack & ~rst;
   assign data_valid  = r_data_valid;
   assign busy        = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err  = w_parity_err & ~rst;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed frames, expected events queued by
// the stimulus and checked by an independent monitor.
module tb_uart_rx_ctrl;

   localparam int EV_SHIFT = 0;
   localparam int EV_VALID = 1;
   localparam int EV_FRAME = 2;
   localparam int EV_OVR   = 3;
   localparam int EV_PAR   = 4;
   localparam int DIV      = 4;

   typedef struct {
      int         kind;
      logic [7:0] val;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic baud_tick = 1'b0;
   logic rx_in = 1'b1;
   logic data_ack = 1'b0;
   logic shift, sipo_in, data_valid, frame_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
   logic parity_err;
`endif

   ev_t        exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         tick_cnt = 0;
   int         start_tick = 0;
   int         last_shift_tick = 0;
   int         exp_first_lat = 24;
   int         shift_seen = 0;
   bit         first_pending = 1'b0;
   bit         tick_always = 1'b0;
   logic       prev_dv = 1'b0;
   logic [7:0] model = 8'h00;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .baud_tick   (baud_tick),
      .rx_in       (rx_in),
      .data_ack    (data_ack),
      .shift       (shift),
      .sipo_in     (sipo_in),
      .data_valid  (data_valid),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .busy        (busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   // Baud tick generator: one tick every DIV clocks, or every clock when tick_always.
   initial begin
      int div_cnt;
      div_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         div_cnt   = (div_cnt + 1) % DIV;
         baud_tick = tick_always || (div_cnt == 0);
      end
   end

   // Count ticks actually seen by the DUT at each rising edge.
   always @(posedge clk) if (baud_tick) tick_cnt <= tick_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic ev_check(input int kind, input logic [7:0] val, input string name);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: unexpected event kind %0d value %0h, expected none at %0t",
                  name, kind, val, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val !== val) begin
            n_fail++;
            $display("FAIL %s: got kind %0d value %0h, expected kind %0d value %0h at %0t",
                     name, kind, val, e.kind, e.val, $time);
         end
      end
   endtask

   function automatic void push_ev(input int kind, input logic [7:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endfunction

   // Queue the eight shifts of byte b followed by an optional end-of-frame event.
   function automatic void push_frame(input logic [7:0] b, input int end_kind);
      for (int i = 0; i < 8; i++) push_ev(EV_SHIFT, {7'b0, b[i]});
      if (end_kind == EV_VALID) push_ev(EV_VALID, b);
      else if (end_kind >= 0)   push_ev(end_kind, 8'h00);
   endfunction

   // Monitor: turns DUT output activity into events and checks tick timing.
   initial begin
      int cur;
      forever begin
         @(negedge clk);
         if (shift) begin
            shift_seen++;
            ev_check(EV_SHIFT, {7'b0, sipo_in}, "shift_bit");
            cur = tick_cnt + 1;
            if (first_pending) begin
               chk("first_shift_latency", cur - start_tick, exp_first_lat);
               first_pending = 1'b0;
            end else begin
               chk("shift_spacing", cur - last_shift_tick, 16);
            end
            last_shift_tick = cur;
            model = {sipo_in, model[7:1]};
         end
         if (data_valid && !prev_dv) ev_check(EV_VALID, model, "valid_byte");
         if (frame_err)              ev_check(EV_FRAME, 8'h00, "frame_err");
         if (overrun_err)            ev_check(EV_OVR, 8'h00, "overrun_err");
`ifdef UART_RX_PARITY_EN
         if (parity_err)             ev_check(EV_PAR, 8'h00, "parity_err");
`endif
         prev_dv = data_valid;
      end
   end

   // Returns 1 ns after the rising edge that consumed the n-th tick.
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (baud_tick !== 1'b1);
      end
      #1;
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      wait_ticks(n);
   endtask

   // Drive one frame, 16 ticks per bit, LSB first; line left at the stop level.
   task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                             input bit has_par, input logic par_bit);
      rx_in         = 1'b0;
      start_tick    = tick_cnt;
      first_pending = 1'b1;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         wait_ticks(16);
      end
      if (has_par) begin
         rx_in = par_bit;
         wait_ticks(16);
      end
      rx_in = stop_lvl;
      wait_ticks(16);
   endtask

   task automatic ack_byte(input string name);
      @(negedge clk);
      chk({name, "_held"}, int'(data_valid), 1);
      @(posedge clk);
      #1 data_ack = 1'b1;
      @(posedge clk);
      #1 data_ack = 1'b0;
      @(negedge clk);
      chk({name, "_cleared"}, int'(data_valid), 0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_shift"},   int'(shift), 0);
      chk({name, "_sipo"},    int'(sipo_in), 0);
      chk({name, "_valid"},   int'(data_valid), 0);
      chk({name, "_frame"},   int'(frame_err), 0);
      chk({name, "_overrun"}, int'(overrun_err), 0);
      chk({name, "_busy"},    int'(busy), 0);
   endtask

   initial begin
      #600000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int budget;

      // Reset state, while held and after release.
      repeat (3) @(negedge clk);
      chk_all_zero("reset_held");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_all_zero("reset_release");

      // 0xA5: eight shifts, first at tick 24, valid after a good stop.
      idle(10);
      push_frame(8'hA5, EV_VALID);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      idle(20);
      ack_byte("a5");

      // Five-tick glitch: leaves START at mid start bit, no events.
      idle(10);
      rx_in = 1'b0;
      wait_ticks(2);
      @(negedge clk);
      chk("glitch_busy_in_start", int'(busy), 1);
      wait_ticks(3);
      rx_in = 1'b1;
      wait_ticks(6);
      @(negedge clk);
      chk("glitch_busy_after_mid", int'(busy), 0);

      // 0x3C with stop low: frame error, no valid, no retrigger while low.
      idle(20);
      push_frame(8'h3C, EV_FRAME);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      wait_ticks(20);
      @(negedge clk);
      chk("ferr_no_retrigger_busy", int'(busy), 0);
      chk("ferr_valid_low", int'(data_valid), 0);

      // 0x11 then 0x22 back to back, no ack: overrun at the second stop.
      idle(20);
      push_frame(8'h11, EV_VALID);
      push_frame(8'h22, EV_OVR);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      idle(20);
      @(negedge clk);
      chk("overrun_sipo_overwritten", int'(model), 8'h22);
      ack_byte("overrun");

      // 0x44 unacked, then 0x55 with ack on the stop-sample clock: no overrun.
      idle(20);
      push_frame(8'h44, EV_VALID);
      push_frame(8'h55, -1);
      send_frame(8'h44, 1'b1, 1'b0, 1'b0);
      idle(20);
      fork
         send_frame(8'h55, 1'b1, 1'b0, 1'b0);
         begin
            wait_ticks(151);
            #1;
            while (!baud_tick) begin
               @(posedge clk);
               #2;
            end
            data_ack = 1'b1;
            @(posedge clk);
            #1 data_ack = 1'b0;
         end
      join
      idle(20);
      @(negedge clk);
      chk("ack_on_stop_sipo", int'(model), 8'h55);
      ack_byte("ack_on_stop");

      // Reset after the fourth shift of 0xFF, then a clean 0x0F.
      idle(20);
      for (int i = 0; i < 4; i++) push_ev(EV_SHIFT, 8'h01);
      base = shift_seen;
      fork
         send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
         begin
            budget = 0;
            while (shift_seen < base + 4 && budget < 5000) begin
               @(posedge clk);
               budget++;
            end
            chk("rst_wait_fourth_shift", shift_seen - base, 4);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk_all_zero("mid_frame_reset");
         end
      join
      idle(20);
      push_frame(8'h0F, EV_VALID);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
      idle(20);
      ack_byte("after_reset");

      // baud_tick held high: a tick every clock; sync latency costs three ticks.
      idle(5);
      tick_always = 1'b1;
      wait_ticks(4);
      exp_first_lat = 27;
      push_frame(8'h5A, EV_VALID);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      idle(30);
      ack_byte("tick_always");
      tick_always = 1'b0;
      exp_first_lat = 24;

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so parity bit 1 is correct.
      idle(20);
      push_frame(8'h07, EV_PAR);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      idle(20);
      @(negedge clk);
      chk("parity_bad_no_valid", int'(data_valid), 0);
      push_frame(8'h07, EV_VALID);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      idle(20);
      ack_byte("parity_good");
`endif

      idle(20);
      chk("expected_events_left", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
